// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared state encoding, widths and helpers for the pipeline controller.
// Rev 1.0
`default_nettype none

package pipe_ctrl_pkg;

  localparam int REG_IDX_W       = 4;
  localparam int TIMEOUT_DEFAULT = 255;
  localparam int WAIT_CNT_W      = 8;
  localparam int STALL_CNT_W     = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_t;

  function automatic logic reg_match(
    input logic [REG_IDX_W-1:0] src,
    input logic [REG_IDX_W-1:0] dest,
    input logic                 wb_en
  );
    return wb_en && (src == dest);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect -- combinational RAW hazard check of the ID operands against EXE/MEM.
// Rev 1.0
`default_nettype none

module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] src1,
  input  logic [REG_IDX_W-1:0] src2,
  input  logic                 two_src,
  input  logic [REG_IDX_W-1:0] dest_exe,
  input  logic                 wb_en_exe,
  input  logic                 mem_r_en_exe,
  input  logic [REG_IDX_W-1:0] dest_mem,
  input  logic                 wb_en_mem,
  input  logic                 forward_en,
  output logic                 hz
);

  logic w_exe_match;
  logic w_mem_match;

  assign w_exe_match = reg_match(src1, dest_exe, wb_en_exe)
                     || (two_src && reg_match(src2, dest_exe, wb_en_exe));
  assign w_mem_match = reg_match(src1, dest_mem, wb_en_mem)
                     || (two_src && reg_match(src2, dest_mem, wb_en_mem));

  // With forwarding only a load result in EXE cannot be bypassed in time.
  assign hz = forward_en ? (mem_r_en_exe && w_exe_match)
                         : (w_exe_match || w_mem_match);

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline freeze/flush control with memory-wait FSM and stall counter.
// Rev 1.0
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_IDX_W-1:0]   src1_ID,
  input  logic [REG_IDX_W-1:0]   src2_ID,
  input  logic                   two_src_ID,
  input  logic [REG_IDX_W-1:0]   dest_EXE,
  input  logic                   WB_EN_EXE,
  input  logic                   MEM_R_EN_EXE,
  input  logic [REG_IDX_W-1:0]   dest_MEM,
  input  logic                   WB_EN_MEM,
  input  logic                   branch_taken_EXE,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  input  logic                   forward_en,
  output logic                   freeze_IF,
  output logic                   freeze_ID,
  output logic                   freeze_EXE,
  output logic                   flush_IF,
  output logic                   flush_ID,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [WAIT_CNT_W-1:0]   r_wait_cnt;
  logic [STALL_CNT_W-1:0]  r_stall_cnt;
  logic                    r_mem_err;
  logic                    w_hz;
  logic                    w_mstall;
  logic                    w_wait_expired;

  hazard_detect u_hazard_detect (
    .src1         (src1_ID),
    .src2         (src2_ID),
    .two_src      (two_src_ID),
    .dest_exe     (dest_EXE),
    .wb_en_exe    (WB_EN_EXE),
    .mem_r_en_exe (MEM_R_EN_EXE),
    .dest_mem     (dest_MEM),
    .wb_en_mem    (WB_EN_MEM),
    .forward_en   (forward_en),
    .hz           (w_hz)
  );

  assign w_wait_expired = (r_wait_cnt == WAIT_CNT_W'(TIMEOUT - 1));
  assign w_mstall       = (r_state != RUN) || (mem_req && !mem_ready);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN: begin
        if (mem_req && !mem_ready) w_next_state = MEM_WAIT;
      end
      MEM_WAIT: begin
        // A completing access in the timeout cycle still counts as success.
        if (mem_ready)           w_next_state = RUN;
        else if (w_wait_expired) w_next_state = MEM_ERR;
      end
      MEM_ERR: w_next_state = MEM_ERR;
      default: w_next_state = RUN;
    endcase
  end

  always_comb begin
    freeze_IF  = 1'b0;
    freeze_ID  = 1'b0;
    freeze_EXE = 1'b0;
    flush_IF   = 1'b0;
    flush_ID   = 1'b0;
    if (!rst) begin
      freeze_IF = 1'b0;
    end else if (w_mstall) begin
      freeze_IF  = 1'b1;
      freeze_ID  = 1'b1;
      freeze_EXE = 1'b1;
    end else if (branch_taken_EXE) begin
      flush_IF = 1'b1;
      flush_ID = 1'b1;
    end else if (w_hz) begin
      freeze_IF = 1'b1;
      freeze_ID = 1'b1;
      flush_ID  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_mem_err <= (w_next_state == MEM_ERR);
      if (r_state != MEM_WAIT) r_wait_cnt <= '0;
      else                     r_wait_cnt <= r_wait_cnt + 1'b1;
      if (freeze_IF && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire
